disp_arbiter: RTL and testbench
===============================

DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter: NREQ, 3, number of requesters; fixed at 3.
REQ-002 Parameter: HOLD_CYCLES, 25000000, minimum tenure in clk cycles; 0 is treated as 1.
REQ-003 Parameter: HOLD_W, 25, hold counter width; SHALL hold HOLD_CYCLES-1.
REQ-004 clk  input  1  system clock, all flops rising-edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 req  input  3  display request per requester, level-sensitive.
REQ-007 val  input  48  requester values; requester i on bits [16i+15:16i], nibble 3 leftmost.
REQ-008 dp_in  input  12  requester decimal points; requester i on bits [4i+3:4i], active-low.
REQ-009 gnt  output  3  one-hot grant, all-zero when idle, registered.
REQ-010 hex3, hex2, hex1, hex0  output  4 each  digits for the 7-segment mux, registered.
REQ-011 dp_out  output  4  decimal points for the 7-segment mux, active-low, registered.
REQ-012 active  output  1  high when any grant is held.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, HOLD and OWN.
REQ-014 IDLE: if any req is high, grant the first requesting index after rr_ptr (modulo 3), load hold_cnt=HOLD_CYCLES-1, set rr_ptr=granted index, and go to HOLD.
REQ-015 IDLE: if no req is high, stay; gnt=000, hex*=0, dp_out=4'b1111, active=0.
REQ-016 HOLD: the owner keeps the grant regardless of any req value.
REQ-017 HOLD: hold_cnt decrements each cycle; when hold_cnt==0, go to OWN.
REQ-018 Tenure in HOLD SHALL be exactly HOLD_CYCLES cycles.
REQ-019 OWN: if any non-owner req is high, grant the next requester round-robin after the owner, reload hold_cnt, and go to HOLD.
REQ-020 OWN: if no non-owner req is high and owner req is low, go to IDLE.
REQ-021 OWN: if no non-owner req is high and owner req is high, stay in OWN.
REQ-022 A grant change and its display data SHALL appear on the same clk edge; req-to-gnt latency is 1 cycle.
REQ-023 The handover from owner to next requester SHALL be direct, with no idle gap cycle.
REQ-024 A requester dropping req during HOLD SHALL NOT shorten tenure.
REQ-025 At most one gnt bit SHALL be high in every cycle.
REQ-026 Arbitration SHALL be round-robin with no starvation: a waiting requester is granted within 2 tenures.
REQ-027 rr_ptr SHALL wrap from 2 to 0.

Reset
REQ-028 Reset SHALL force state=IDLE, gnt=000, hex*=0, dp_out=4'b1111, active=0, hold_cnt=0 and rr_ptr=2, so requester 0 wins first.
REQ-029 Reset asserted mid-tenure SHALL abort the tenure immediately, with no cycle delayed.
REQ-030 After reset deassertion, arbitration SHALL restart from IDLE on the next edge.

Configuration
REQ-031 Macro DISP_ARB_SNAPSHOT_EN defined: val/dp_in of the new owner are captured on the grant edge and held constant for the whole tenure.
REQ-032 Macro DISP_ARB_SNAPSHOT_EN undefined: hex*/dp_out are re-registered from the owner's live val/dp_in every cycle, with 1-cycle latency.
REQ-033 Arbitration behaviour SHALL be identical with and without DISP_ARB_SNAPSHOT_EN.

Verification (bench HOLD_CYCLES=4)
REQ-034 After reset, req=001, val[15:0]=16'h1234 -> next edge gnt=001, active=1, hex3..0=1,2,3,4.
REQ-035 Requester 0 owns, req=111 held constant -> gnt sequence 001 (4 cycles), 010 (4 cycles), 100 (4 cycles), 001; no idle gap.
REQ-036 gnt=010 granted, req[1] dropped 1 cycle later -> gnt=010 for 4 cycles total, then 000, dp_out=1111, hex*=0.
REQ-037 Snapshot on, owner changes val from 16'hABCD to 16'h0000 mid-tenure -> display stays ABCD. Snapshot off -> display shows 0000 one cycle after the change.
REQ-038 Reset pulsed during HOLD with gnt=100 -> gnt=000 asynchronously. Then req=101 -> gnt=001 first.
REQ-039 req=000 for 20 cycles after reset -> state IDLE, gnt=000, active=0 throughout.

Source files
------------

// File: rtl/disp_arbiter.sv
// disp_arbiter: round-robin arbiter handing one of three requesters timed ownership of a 4-digit 7-segment display
// Ports: clk, reset (async, active-high), req[2:0], val[47:0] (requester i on [16i+15:16i]),
//        dp_in[11:0] (requester i on [4i+3:4i], active-low) in;
//        gnt[2:0] one-hot, hex3..hex0, dp_out[3:0] (active-low), active out -- all registered.
// Macro DISP_ARB_SNAPSHOT_EN: when defined, the owner's val/dp_in captured on the grant edge are frozen for the tenure;
//        otherwise the display follows the owner's live inputs with one cycle of latency.
module disp_arbiter #(
  parameter int NREQ = 3,
  parameter int HOLD_CYCLES = 25000000,
  parameter int HOLD_W = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   val,
  input  logic [4*NREQ-1:0]    dp_in,
  output logic [NREQ-1:0]      gnt,
  output logic [3:0]           hex3,
  output logic [3:0]           hex2,
  output logic [3:0]           hex1,
  output logic [3:0]           hex0,
  output logic [3:0]           dp_out,
  output logic                 active
);
  typedef enum logic [1:0] {IDLE, HOLD, OWN} state_t;
  localparam logic [HOLD_W-1:0] RELOAD = HOLD_W'((HOLD_CYCLES < 1) ? 0 : HOLD_CYCLES - 1);
  state_t state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0] rr_ptr, p1, p2, idx, src;
  logic decide, grant, release_own;
  logic [15:0] sel_val;
  logic [3:0] sel_dp;
  // rr_ptr doubles as the owner index while a grant is held. The last HOLD
  // cycle already applies the OWN rules so tenure is exactly HOLD_CYCLES.
  always_comb begin
    p1 = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
    p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
    decide = (state == OWN) || (state == HOLD && hold_cnt == '0);
    grant = (state == IDLE) ? |req : decide && (req[p1] || req[p2]);
    release_own = decide && !req[p1] && !req[p2] && !req[rr_ptr];
    idx = req[p1] ? p1 : req[p2] ? p2 : rr_ptr;
    src = grant ? idx : rr_ptr;
    sel_val = val[{src, 4'b0000} +: 16];
    sel_dp = dp_in[{src, 2'b00} +: 4];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hold_cnt <= '0;
      rr_ptr <= 2'd2;
      gnt <= '0;
      active <= 1'b0;
      {hex3, hex2, hex1, hex0} <= 16'h0000;
      dp_out <= 4'hf;
    end else if (grant) begin
      state <= HOLD;
      hold_cnt <= RELOAD;
      rr_ptr <= idx;
      gnt <= NREQ'(1) << idx;
      active <= 1'b1;
      {hex3, hex2, hex1, hex0} <= sel_val;
      dp_out <= sel_dp;
    end else if (release_own) begin
      state <= IDLE;
      gnt <= '0;
      active <= 1'b0;
      {hex3, hex2, hex1, hex0} <= 16'h0000;
      dp_out <= 4'hf;
    end else if (state != IDLE) begin
      if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
      else state <= OWN;
`ifndef DISP_ARB_SNAPSHOT_EN
      {hex3, hex2, hex1, hex0} <= sel_val;
      dp_out <= sel_dp;
`endif
    end
  end
endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: directed and randomized checks of disp_arbiter against a tenure-counting reference model
module tb_disp_arbiter;
  localparam int H = 4;
`ifdef DISP_ARB_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] req = '0;
  logic [47:0] val = '0;
  logic [11:0] dp_in = '1;
  logic [2:0] gnt;
  logic [3:0] hex3, hex2, hex1, hex0, dp_out;
  logic active;
  int n_cmp = 0;
  int n_bad = 0;
  int owner = -1;
  int last = 2;
  int ten = 0;
  logic [15:0] m_hex = '0;
  logic [3:0] m_dp = 4'hf;

  always #5 clk = ~clk;

  disp_arbiter #(.NREQ(3), .HOLD_CYCLES(H), .HOLD_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .val(val), .dp_in(dp_in),
    .gnt(gnt), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .dp_out(dp_out), .active(active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    owner = -1;
    last = 2;
    ten = 0;
    m_hex = '0;
    m_dp = 4'hf;
  endtask

  // One clock edge of the arbiter: owner holds for H cycles, then hands over
  // round-robin to another requester, keeps the display, or releases it.
  task automatic m_step();
    int nx;
    bit load;
    load = 1'b0;
    if (owner < 0) begin
      for (int k = 1; k <= 3; k++) if (owner < 0 && req[(last + k) % 3]) owner = (last + k) % 3;
      if (owner >= 0) begin
        last = owner;
        ten = 1;
        load = 1'b1;
      end
    end else if (ten < H) begin
      ten++;
    end else begin
      nx = -1;
      for (int k = 1; k <= 2; k++) if (nx < 0 && req[(owner + k) % 3]) nx = (owner + k) % 3;
      if (nx >= 0) begin
        owner = nx;
        last = nx;
        ten = 1;
        load = 1'b1;
      end else if (!req[owner]) owner = -1;
    end
    if (owner < 0) begin
      m_hex = '0;
      m_dp = 4'hf;
    end else if (load || !SNAP) begin
      m_hex = val[owner*16 +: 16];
      m_dp = dp_in[owner*4 +: 4];
    end
  endtask

  task automatic cmp_model(input string tag);
    logic [2:0] mg;
    mg = (owner < 0) ? 3'b000 : 3'(1 << owner);
    chk({tag, ".gnt"}, 32'(gnt), 32'(mg));
    chk({tag, ".active"}, 32'(active), 32'(owner >= 0));
    chk({tag, ".hex"}, 32'({hex3, hex2, hex1, hex0}), 32'(m_hex));
    chk({tag, ".dp"}, 32'(dp_out), 32'(m_dp));
    chk({tag, ".onehot"}, 32'($onehot0(gnt)), 32'd1);
  endtask

  task automatic tick(input string tag);
    m_step();
    @(negedge clk);
    cmp_model(tag);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1 m_reset();
    cmp_model("rst_async");
    @(negedge clk);
    cmp_model("rst_held");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    m_reset();
    @(negedge clk);
    chk("reset.gnt", 32'(gnt), 32'd0);
    chk("reset.active", 32'(active), 32'd0);
    chk("reset.hex", 32'({hex3, hex2, hex1, hex0}), 32'h0);
    chk("reset.dp", 32'(dp_out), 32'hf);
    @(negedge clk);
    reset = 1'b0;
    // quiet after reset: nothing granted
    req = 3'b000;
    repeat (20) begin
      tick("idle");
      chk("idle.gnt", 32'(gnt), 32'd0);
      chk("idle.active", 32'(active), 32'd0);
    end
    // requester 0 wins first after reset
    req = 3'b001;
    val = 48'h0;
    val[15:0] = 16'h1234;
    dp_in = 12'hea7;
    tick("first");
    chk("first.gnt", 32'(gnt), 32'd1);
    chk("first.active", 32'(active), 32'd1);
    chk("first.hex", 32'({hex3, hex2, hex1, hex0}), 32'h1234);
    chk("first.dp", 32'(dp_out), 32'h7);
    // all requesting: 4-cycle tenures rotate with no gap
    req = 3'b111;
    for (int t = 1; t <= 12; t++) begin
      tick("rr");
      chk("rr.seq", 32'(gnt), (t <= 3) ? 32'd1 : (t <= 7) ? 32'd2 : (t <= 11) ? 32'd4 : 32'd1);
    end
    // requester 1 granted then drops at once: tenure still 4 cycles
    req = 3'b010;
    repeat (3) tick("to1");
    tick("to1");
    chk("drop.grant", 32'(gnt), 32'd2);
    req = 3'b000;
    repeat (3) begin
      tick("drop");
      chk("drop.hold", 32'(gnt), 32'd2);
    end
    tick("drop_end");
    chk("drop.gnt", 32'(gnt), 32'd0);
    chk("drop.hex", 32'({hex3, hex2, hex1, hex0}), 32'h0);
    chk("drop.dp", 32'(dp_out), 32'hf);
    // live versus snapshot display
    req = 3'b001;
    val[15:0] = 16'habcd;
    tick("snap_g");
    chk("snap.load", 32'({hex3, hex2, hex1, hex0}), 32'habcd);
    val[15:0] = 16'h0000;
    tick("snap_c");
    chk("snap.after", 32'({hex3, hex2, hex1, hex0}), SNAP ? 32'habcd : 32'h0);
    // reset mid-tenure while requester 2 owns
    req = 3'b100;
    repeat (2) tick("to2");
    tick("to2");
    chk("mid.grant", 32'(gnt), 32'd4);
    tick("mid");
    #2 reset = 1'b1;
    #1 chk("mid.async_gnt", 32'(gnt), 32'd0);
    chk("mid.async_active", 32'(active), 32'd0);
    m_reset();
    @(negedge clk);
    cmp_model("mid_rst");
    reset = 1'b0;
    req = 3'b101;
    tick("after_rst");
    chk("after_rst.gnt", 32'(gnt), 32'd1);
    // randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else begin
        if ($urandom_range(0, 3) == 0) req = 3'($urandom);
        val = {16'($urandom), 32'($urandom)};
        dp_in = 12'($urandom);
        tick("rnd");
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
